regfile_dump: RTL and testbench

Debug read-out engine for the MIPS core's register file, the read-side counterpart to preloading registers and instruction memory at start-up.
- On a start pulse it asserts core_halt, reads every register through a read port, and streams each value out on a valid/ready interface with its register index.
- Sits beside the MIPS core; its stream goes to a bench monitor or a debug UART.

---
 rtl/mips_dbg_pkg.sv | 17 +
 rtl/dump_out_reg.sv | 40 ++++
 rtl/regfile_dump.sv | 155 +++++++++++++++
 tb/tb_regfile_dump.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_dbg_pkg.sv
// Shared debug definitions for the MIPS core: register-file geometry and the
// dump engine FSM state encoding.
package mips_dbg_pkg;

    localparam int RF_NUM_REGS = 32;
    localparam int RF_DATA_W   = 32;
    localparam int RF_IDX_W    = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_READ,
        ST_SEND,
        ST_FIN
    } dump_state_t;

endpackage

// File: rtl/dump_out_reg.sv
// Valid/ready output holding register for the register-file dump stream.
// Captured word stays stable while the consumer stalls.
module dump_out_reg #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [IDX_W-1:0]  load_idx,
    input  logic              load_last,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              fire
);

    assign fire = out_valid & out_ready;

    // Payload only moves on load; a handshake just retires the valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_idx   <= load_idx;
            out_last  <= load_last;
        end else if (fire) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_dump.sv
// Register-file dump engine: halts the core, streams every register with its
// index. Define REGFILE_DUMP_CSUM_EN to append an XOR checksum beat.
module regfile_dump
    import mips_dbg_pkg::*;
#(
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int DATA_W   = RF_DATA_W,
    parameter int IDX_W    = RF_IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              core_halt,
    output logic [IDX_W-1:0]  rf_rd_addr,
    input  logic [DATA_W-1:0] rf_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    dump_state_t       state, state_nxt;
    logic [IDX_W-1:0]  cnt, cnt_nxt;
    logic              busy_nxt;
    logic              load;
    logic              fire;
    logic [DATA_W-1:0] load_data;
    logic [IDX_W-1:0]  load_idx;
    logic              load_last;

`ifdef REGFILE_DUMP_CSUM_EN
    logic              csum_beat, csum_beat_nxt;
    logic [DATA_W-1:0] acc, acc_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            csum_beat <= 1'b0;
            acc       <= '0;
        end else begin
            csum_beat <= csum_beat_nxt;
            acc       <= acc_nxt;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            busy  <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy_nxt  = busy;
        load      = 1'b0;
        load_data = rf_rd_data;
        load_idx  = cnt;
        load_last = (cnt == LAST_IDX);
`ifdef REGFILE_DUMP_CSUM_EN
        csum_beat_nxt = csum_beat;
        acc_nxt       = acc;
        load_last     = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_HALT;
                    busy_nxt  = 1'b1;
                    cnt_nxt   = '0;
`ifdef REGFILE_DUMP_CSUM_EN
                    csum_beat_nxt = 1'b0;
                    acc_nxt       = '0;
`endif
                end
            end
            // One dead cycle lets a core write already in flight retire.
            ST_HALT: state_nxt = ST_READ;
            ST_READ: begin
                load      = 1'b1;
                state_nxt = ST_SEND;
`ifdef REGFILE_DUMP_CSUM_EN
                if (csum_beat) begin
                    load_data = acc;
                    load_idx  = '0;
                    load_last = 1'b1;
                end else begin
                    acc_nxt = acc ^ rf_rd_data;
                end
`endif
            end
            ST_SEND: begin
                if (fire) begin
`ifdef REGFILE_DUMP_CSUM_EN
                    if (csum_beat) begin
                        state_nxt = ST_FIN;
                    end else if (cnt == LAST_IDX) begin
                        csum_beat_nxt = 1'b1;
                        state_nxt     = ST_READ;
                    end else begin
                        cnt_nxt   = cnt + 1'b1;
                        state_nxt = ST_READ;
                    end
`else
                    if (cnt == LAST_IDX) begin
                        state_nxt = ST_FIN;
                    end else begin
                        cnt_nxt   = cnt + 1'b1;
                        state_nxt = ST_READ;
                    end
`endif
                end
            end
            ST_FIN: begin
                busy_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign core_halt  = busy;
    assign done       = (state == ST_FIN);
    assign rf_rd_addr = cnt;

    dump_out_reg #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_out (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (load_data),
        .load_idx  (load_idx),
        .load_last (load_last),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .fire      (fire)
    );

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: table of dump scenarios checked through a beat
// scoreboard, with stall, restart, FIN-start and mid-dump reset sequences.
module tb_regfile_dump;

    localparam int NREG = 32;
`ifdef REGFILE_DUMP_CSUM_EN
    localparam int FULL_BEATS = NREG + 1;
`else
    localparam int FULL_BEATS = NREG;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, core_halt;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [4:0]  out_idx;
    logic        out_last;
    logic        done;

    logic [31:0] regs [NREG];
    logic        core_we = 1'b0;

    int compared = 0;
    int mismatched = 0;
    int done_cnt = 0;
    int beat_cnt = 0;
    int blocked_writes = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  idx;
        logic        last;
    } beat_t;
    beat_t exp_q[$];

    typedef struct {
        int          ia;
        logic [31:0] va;
        int          ib;
        logic [31:0] vb;
        bit          do_add;
        int          stall_idx;
        int          stall_len;
        int          restart_idx;
        int          rst_idx;
        bit          fin_start;
        int          exp_beats;
        int          exp_done;
    } vec_t;
    vec_t vecs[6];

    regfile_dump dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .core_halt  (core_halt),
        .rf_rd_addr (rf_rd_addr),
        .rf_rd_data (rf_rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .done       (done)
    );

    always #5 clk = ~clk;

    assign rf_rd_data = regs[rf_rd_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Core model: any write it gets through while a dump is running is a fault.
    always @(posedge clk) begin
        if (core_we && !core_halt) blocked_writes++;
    end

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (out_valid && out_ready && !rst) begin
            beat_t e;
            beat_cnt++;
            check("halt_during_beat", {31'd0, core_halt}, 32'd1);
            if (exp_q.size() == 0) begin
                check("unexpected_beat_idx", {27'd0, out_idx}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", out_data, e.data);
                check("beat_idx", {27'd0, out_idx}, {27'd0, e.idx});
                check("beat_last", {31'd0, out_last}, {31'd0, e.last});
            end
        end
    end

    task automatic push_expected();
        beat_t b;
        logic [31:0] x;
        x = '0;
        for (int r = 0; r < NREG; r++) begin
            b.data = regs[r];
            b.idx  = 5'(r);
`ifdef REGFILE_DUMP_CSUM_EN
            b.last = 1'b0;
`else
            b.last = (r == NREG - 1);
`endif
            x = x ^ regs[r];
            exp_q.push_back(b);
        end
`ifdef REGFILE_DUMP_CSUM_EN
        b.data = x;
        b.idx  = 5'd0;
        b.last = 1'b1;
        exp_q.push_back(b);
`endif
    endtask

    // Entered and left #1 after a rising edge.
    task automatic run_dump(input vec_t v);
        int dc0, bc0, cyc;
        bit fin, stalled, restarted;
        logic [31:0] hd;
        logic [4:0]  hi;
        dc0 = done_cnt;
        bc0 = beat_cnt;
        blocked_writes = 0;
        fin = 0; stalled = 0; restarted = 0; cyc = 0;
        push_expected();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("halt_eq_busy", {31'd0, core_halt}, 32'd1);
        core_we = 1'b1;
        @(posedge clk); #1;
        check("no_valid_at_n1", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check("valid_at_n2", {31'd0, out_valid}, 32'd1);
        check("first_idx", {27'd0, out_idx}, 32'd0);
        while (!fin && cyc < 600) begin
            if (v.stall_idx >= 0 && !stalled && out_valid && int'(out_idx) == v.stall_idx) begin
                stalled = 1;
                out_ready = 1'b0;
                hd = out_data;
                hi = out_idx;
                repeat (v.stall_len) begin
                    @(posedge clk); #1;
                    check("stall_valid", {31'd0, out_valid}, 32'd1);
                    check("stall_data", out_data, hd);
                    check("stall_idx", {27'd0, out_idx}, {27'd0, hi});
                end
                out_ready = 1'b1;
            end
            if (v.restart_idx >= 0 && !restarted && out_valid && int'(out_idx) == v.restart_idx) begin
                restarted = 1;
                start = 1'b1;
            end
            if (v.rst_idx >= 0 && out_valid && int'(out_idx) == v.rst_idx) begin
                out_ready = 1'b0;
                core_we = 1'b0;
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                out_ready = 1'b1;
                check("rst_valid", {31'd0, out_valid}, 32'd0);
                check("rst_busy", {31'd0, busy}, 32'd0);
                check("rst_halt", {31'd0, core_halt}, 32'd0);
                check("rst_done", {31'd0, done}, 32'd0);
                exp_q.delete();
                fin = 1;
            end else if (done) begin
                fin = 1;
                core_we = 1'b0;
                if (v.fin_start) start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                check("busy_after_fin", {31'd0, busy}, 32'd0);
                check("halt_after_fin", {31'd0, core_halt}, 32'd0);
                check("done_width", {31'd0, done}, 32'd0);
            end else begin
                @(posedge clk); #1;
                start = 1'b0;
                cyc++;
            end
        end
        if (!fin) check("done_timeout", 32'd0, 32'd1);
        core_we = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("beat_count", beat_cnt - bc0, v.exp_beats);
        check("done_count", done_cnt - dc0, v.exp_done);
        check("queue_drained", exp_q.size(), 32'd0);
        check("no_core_writes", blocked_writes, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           ia  va            ib  vb            add stl len rst  rsti fin beats       done
        vecs[0] = '{16, 32'h000004D2, 17, 32'h0000162E, 0, -1, 0, -1, -1, 0, FULL_BEATS, 1};
        vecs[1] = '{16, 32'h000004D2, 17, 32'h0000162E, 1, -1, 0, -1, -1, 0, FULL_BEATS, 1};
        vecs[2] = '{3,  32'hA5A5_0003, 4,  32'h5A5A_0004, 0,  3, 5, -1, -1, 0, FULL_BEATS, 1};
        vecs[3] = '{16, 32'h000004D2, 17, 32'h0000162E, 0, -1, 0, 10, -1, 1, FULL_BEATS, 1};
        vecs[4] = '{16, 32'h000004D2, 17, 32'h0000162E, 0, -1, 0, -1,  7, 0, 7,          0};
        vecs[5] = '{0,  32'h1234_5678, 31, 32'hFFFF_FFFF, 0, -1, 0, -1, -1, 0, FULL_BEATS, 1};

        for (int r = 0; r < NREG; r++) regs[r] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_halt", {31'd0, core_halt}, 32'd0);
        check("reset_valid", {31'd0, out_valid}, 32'd0);
        check("reset_last", {31'd0, out_last}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_addr", {27'd0, rf_rd_addr}, 32'd0);
        check("reset_idx", {27'd0, out_idx}, 32'd0);
        check("reset_data", out_data, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_ready_no_effect", {31'd0, out_valid}, 32'd0);

        for (int k = 0; k < 6; k++) begin
            for (int r = 0; r < NREG; r++) regs[r] = '0;
            regs[vecs[k].ia] = vecs[k].va;
            regs[vecs[k].ib] = vecs[k].vb;
            if (vecs[k].do_add) regs[18] = regs[16] + regs[17];
            run_dump(vecs[k]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
